rank_generator: RTL and testbench

//  Streaming producer of the packed sample/rank bus used by the rank-order filter datapath.

---
 rtl/rank_generator_pkg.sv | 23 ++
 rtl/rank_generator_cell.sv | 34 +++
 rtl/rank_generator.sv | 114 +++++++++++
 tb/tb_rank_generator.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rank_generator_pkg.sv
// Shared types and helpers for the rank_generator window/rank datapath.
package rank_generator_pkg;

    typedef enum logic [0:0] {
        FILL = 1'b0,
        RUN  = 1'b1
    } state_e;

    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(v)) r = i + 1;
        end
        return r;
    endfunction

    // Slot index width; never below one bit so a single-bit port stays legal.
    function automatic int unsigned idx_bits(input int unsigned n);
        return (n < 2) ? 1 : clog2(n);
    endfunction

endpackage

// File: rtl/rank_generator_cell.sv
// Rank of one window slot: count of smaller samples plus equal samples in newer slots.
module rank_generator_cell
    import rank_generator_pkg::*;
#(
    parameter int unsigned N         = 3,
    parameter int unsigned data_bits = 8,
    parameter int unsigned rank_bits = 2,
    parameter int unsigned IDX_BITS  = idx_bits(N)
) (
    input  logic [data_bits*N-1:0] win_i,
    input  logic [IDX_BITS-1:0]    slot_i,
    output logic [rank_bits-1:0]   rank_c
);

    always_comb begin
        int unsigned          acc;
        int unsigned          own_idx;
        logic [data_bits-1:0] own;
        logic [data_bits-1:0] other;
        acc     = 0;
        own_idx = 32'(slot_i);
        own     = win_i[own_idx*data_bits +: data_bits];
        other   = '0;
        // Ties resolve toward the newer (lower-index) slot getting the lower rank.
        for (int unsigned j = 0; j < N; j++) begin
            other = win_i[j*data_bits +: data_bits];
            if (j != own_idx) begin
                if ((other < own) || ((other == own) && (j < own_idx))) acc++;
            end
        end
        rank_c = rank_bits'(acc);
    end

endmodule

// File: rtl/rank_generator.sv
// Sliding-window sample/rank producer: window shift register, ranking stage, output register, fill FSM.
// RANK_GEN_WARMUP_EN: when defined, outputs follow every accept from the first sample (no fill wait).
module rank_generator
    import rank_generator_pkg::*;
#(
    parameter int unsigned N         = 3,
    parameter int unsigned data_bits = 8,
    parameter int unsigned rank_bits = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [data_bits-1:0]   in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [data_bits*N-1:0] s_out,
    output logic [rank_bits*N-1:0] r_out
);

    localparam int unsigned IDX_BITS = idx_bits(N);
    localparam int unsigned CNT_BITS = clog2(N + 1);

    if (((64'(1) << rank_bits) < 64'(N)) || (N < 2)) begin : g_bad_cfg
        $error("rank_generator: need N >= 2 and 2**rank_bits >= N");
    end

    state_e                 state_q;
    logic [CNT_BITS-1:0]    cnt_q;
    logic [data_bits*N-1:0] win_q, win_d;
    logic                   v1_q;
    logic                   p1_q;
    logic                   out_valid_q;
    logic [data_bits*N-1:0] s_out_q;
    logic [rank_bits*N-1:0] r_out_q;
    logic [rank_bits*N-1:0] rank_c;
    logic                   load_c;
    logic                   accept_c;
    logic                   produce_c;

    for (genvar g = 0; g < N; g++) begin : g_cell
        rank_generator_cell #(
            .N         (N),
            .data_bits (data_bits),
            .rank_bits (rank_bits),
            .IDX_BITS  (IDX_BITS)
        ) u_cell (
            .win_i  (win_q),
            .slot_i (IDX_BITS'(g)),
            .rank_c (rank_c[g*rank_bits +: rank_bits])
        );
    end

    assign load_c   = v1_q && (!out_valid_q || out_ready);
    assign in_ready = !v1_q || load_c;
    assign accept_c = in_valid && in_ready && !flush;
    assign win_d    = {win_q[data_bits*(N-1)-1:0], in_data};

    // Whether the sample being accepted now yields an output once it reaches stage 2.
`ifdef RANK_GEN_WARMUP_EN
    assign produce_c = 1'b1;
`else
    assign produce_c = (state_q == RUN) || (cnt_q == CNT_BITS'(N - 1));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= FILL;
            cnt_q       <= '0;
            win_q       <= '0;
            v1_q        <= 1'b0;
            p1_q        <= 1'b0;
            out_valid_q <= 1'b0;
            s_out_q     <= '0;
            r_out_q     <= '0;
        end else if (flush) begin
            state_q     <= FILL;
            cnt_q       <= '0;
            win_q       <= '0;
            v1_q        <= 1'b0;
            p1_q        <= 1'b0;
            out_valid_q <= 1'b0;
            s_out_q     <= '0;
            r_out_q     <= '0;
        end else begin
            v1_q <= accept_c || (v1_q && !load_c);
            if (accept_c) begin
                win_q <= win_d;
                p1_q  <= produce_c;
                case (state_q)
                    FILL: begin
                        cnt_q <= cnt_q + CNT_BITS'(1);
                        if (cnt_q == CNT_BITS'(N - 1)) state_q <= RUN;
                    end
                    RUN:     state_q <= RUN;
                    default: state_q <= FILL;
                endcase
            end
            if (load_c) begin
                s_out_q     <= win_q;
                r_out_q     <= rank_c;
                out_valid_q <= p1_q;
            end else if (out_ready) begin
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid = out_valid_q;
    assign s_out     = s_out_q;
    assign r_out     = r_out_q;

endmodule

// File: tb/tb_rank_generator.sv
// Bench for rank_generator (N=3): vector table, directed corner sequences, random scoreboard.
module tb_rank_generator;

`ifdef RANK_GEN_WARMUP_EN
    localparam bit WARM = 1'b1;
`else
    localparam bit WARM = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [7:0]  in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [23:0] s_out;
    logic [5:0]  r_out;

    rank_generator #(.N(3), .data_bits(8), .rank_bits(2)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s_out     (s_out),
        .r_out     (r_out)
    );

    always #5 clk = ~clk;

    int n_total = 0;
    int n_bad   = 0;
    int n_xfer  = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic [23:0] s;
        logic [5:0]  r;
    } exp_t;

    logic [7:0]  hist[$];
    int          fill = 0;
    exp_t        exp_q[$];
    bit          hold_pending = 1'b0;
    logic [23:0] held_s;
    logic [5:0]  held_r;

    // Expected window: newest sample in slot 0; ranks from a stable sort by (value, slot).
    function automatic exp_t model_window();
        logic [7:0] v[3];
        int         ord[3];
        int         t;
        exp_t       e;
        for (int k = 0; k < 3; k++) v[k] = (k < hist.size()) ? hist[k] : 8'd0;
        ord = '{0, 1, 2};
        for (int p = 0; p < 2; p++) begin
            for (int a = 0; a < 2; a++) begin
                if ((v[ord[a]] > v[ord[a+1]]) ||
                    ((v[ord[a]] == v[ord[a+1]]) && (ord[a] > ord[a+1]))) begin
                    t = ord[a]; ord[a] = ord[a+1]; ord[a+1] = t;
                end
            end
        end
        e.s = {v[2], v[1], v[0]};
        e.r = '0;
        for (int pos = 0; pos < 3; pos++) e.r[ord[pos]*2 +: 2] = 2'(pos);
        return e;
    endfunction

    task automatic model_accept(input logic [7:0] d);
        hist.push_front(d);
        if (hist.size() > 3) void'(hist.pop_back());
        if (fill < 3) fill++;
        if (WARM || fill == 3) exp_q.push_back(model_window());
    endtask

    task automatic model_clear();
        hist.delete();
        fill = 0;
        exp_q.delete();
        hold_pending = 1'b0;
    endtask

    function automatic bit is_perm(input logic [5:0] r);
        logic [3:0] seen;
        seen = '0;
        for (int k = 0; k < 3; k++) seen[r[k*2 +: 2]] = 1'b1;
        return seen == 4'b0111;
    endfunction

    function automatic logic [7:0] sel_rank(input logic [23:0] s, input logic [5:0] r, input int k);
        logic [7:0] res;
        res = '0;
        for (int i = 0; i < 3; i++) if (32'(r[i*2 +: 2]) == k) res = s[i*8 +: 8];
        return res;
    endfunction

    // Monitor: sampled at negedge, acts on what the next rising edge will commit.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (hold_pending) chk("hold_stable", {out_valid, r_out, s_out}, {1'b1, held_r, held_s});
            hold_pending = out_valid && !out_ready && !flush;
            held_s = s_out;
            held_r = r_out;
            if (out_valid && out_ready) begin
                n_xfer++;
                chk("perm", 32'(is_perm(r_out)), 32'd1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", 32'(out_valid), 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("sb_s", 32'(s_out), 32'(e.s));
                    chk("sb_r", 32'(r_out), 32'(e.r));
                end
            end
            if (flush) model_clear();
            else if (in_valid && in_ready) model_accept(in_data);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic feed(input logic [7:0] v);
        in_valid = 1'b1;
        in_data  = v;
        step();
        in_valid = 1'b0;
    endtask

    task automatic do_flush();
        flush    = 1'b1;
        in_valid = 1'b0;
        step();
        flush = 1'b0;
    endtask

    task automatic wait_out(input string nm);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = out_valid;
        end
        if (!seen) chk(nm, 32'd0, 32'd1);
    endtask

    typedef struct {
        logic [7:0]  d0, d1, d2;
        logic [23:0] s;
        logic [5:0]  r;
        logic [7:0]  med;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int          x0;
        int          v;
        int          hold;
        bit          acc;
        bit          saw_low;
        bit          any_out;

        tbl[0] = '{8'd5,   8'd9,   8'd1,   24'h050901, 6'b01_10_00, 8'd5};
        tbl[1] = '{8'd4,   8'd4,   8'd4,   24'h040404, 6'b10_01_00, 8'd4};
        tbl[2] = '{8'd0,   8'd255, 8'd128, 24'h00FF80, 6'b00_10_01, 8'd128};
        tbl[3] = '{8'd7,   8'd7,   8'd3,   24'h070703, 6'b10_01_00, 8'd7};
        tbl[4] = '{8'd9,   8'd2,   8'd9,   24'h090209, 6'b10_00_01, 8'd9};
        tbl[5] = '{8'd200, 8'd100, 8'd150, 24'hC86496, 6'b10_00_01, 8'd150};

        // Reset state
        #1;
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_s", 32'(s_out), 32'd0);
        chk("rst_r", 32'(r_out), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        #11 rst_n = 1'b1;
        step();

`ifndef RANK_GEN_WARMUP_EN
        // Vector table: three samples after flush give exactly one ranked window
        for (int i = 0; i < 6; i++) begin
            out_ready = 1'b1;
            do_flush();
            x0 = n_xfer;
            feed(tbl[i].d0);
            feed(tbl[i].d1);
            feed(tbl[i].d2);
            wait_out($sformatf("tbl%0d_timeout", i));
            chk($sformatf("tbl%0d_s", i), 32'(s_out), 32'(tbl[i].s));
            chk($sformatf("tbl%0d_r", i), 32'(r_out), 32'(tbl[i].r));
            chk($sformatf("tbl%0d_med", i), 32'(sel_rank(s_out, r_out, 1)), 32'(tbl[i].med));
            step(); step(); step();
            chk($sformatf("tbl%0d_count", i), 32'(n_xfer - x0), 32'd1);
        end

        // Ties persist once the window is all equal
        do_flush();
        feed(8'd4); feed(8'd4); feed(8'd4);
        feed(8'd4);
        wait_out("tie_timeout");
        chk("tie_r", 32'(r_out), 32'(6'b10_01_00));
        step();

        // Backpressure: hold out_ready low for three cycles after the first output
        do_flush();
        x0 = n_xfer; v = 1; hold = 0; saw_low = 1'b0;
        for (int c = 0; c < 40 && v <= 6; c++) begin
            in_valid  = 1'b1;
            in_data   = 8'(v);
            out_ready = !(hold > 0);
            @(negedge clk);
            if (!in_ready) saw_low = 1'b1;
            acc = in_ready;
            step();
            if (hold > 0) hold--;
            if (acc) begin
                if (v == 3) hold = 3;
                v++;
            end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int c = 0; c < 6; c++) step();
        chk("bp_all_sent", 32'(v), 32'd7);
        chk("bp_ready_drop", 32'(saw_low), 32'd1);
        chk("bp_count", 32'(n_xfer - x0), 32'd4);
        chk("bp_drained", 32'(exp_q.size()), 32'd0);

        // Flush together with a valid sample mid-stream
        do_flush();
        feed(8'd1); feed(8'd2); feed(8'd3); feed(8'd4);
        flush = 1'b1; in_valid = 1'b1; in_data = 8'hAA;
        step();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("flush_valid", 32'(out_valid), 32'd0);
        step();
        feed(8'd10); feed(8'd20);
        any_out = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            any_out |= out_valid;
        end
        chk("flush_refill", 32'(any_out), 32'd0);
        step();
        feed(8'd30);
        wait_out("flush_timeout");
        chk("flush_s", 32'(s_out), 32'h0A141E);
        chk("flush_r", 32'(r_out), 32'(6'b00_01_10));
        step();

        // Asynchronous reset mid-stream
        feed(8'd1); feed(8'd2); feed(8'd3); feed(8'd4);
        @(posedge clk);
        #3 rst_n = 1'b0;
        model_clear();
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_s", 32'(s_out), 32'd0);
        chk("arst_r", 32'(r_out), 32'd0);
        chk("arst_ready", 32'(in_ready), 32'd1);
        #3 rst_n = 1'b1;
        step();
        feed(8'd50); feed(8'd60);
        @(negedge clk);
        chk("arst_fill", 32'(out_valid), 32'd0);
        step();
        feed(8'd70);
        wait_out("arst_timeout");
        chk("arst_s2", 32'(s_out), 32'h323C46);
        chk("arst_r2", 32'(r_out), 32'(6'b00_01_10));
        step();
`else
        // Warm-up: the very first sample produces an output with zero-filled slots
        do_flush();
        feed(8'd7);
        wait_out("warm_timeout");
        chk("warm_s", 32'(s_out), 32'h000007);
        chk("warm_r", 32'(r_out), 32'(6'b01_00_10));
        step();
`endif

        // Random traffic against the scoreboard
        for (int c = 0; c < 800; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_data   = ($urandom_range(0, 1) != 0) ? 8'($urandom_range(0, 3)) : 8'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 59) == 0);
            step();
        end
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 6; c++) step();
        chk("rand_drained", 32'(exp_q.size()), 32'd0);
        chk("rand_traffic", 32'(n_xfer > 50), 32'd1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
